// File: rtl/pipe_pkg.sv
// pipe_pkg: types and helpers shared by the preprocessing pipeline blocks
package pipe_pkg;
    localparam int DATA_W_DEF = 8;
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    function automatic int min_cnt_w(input int img_w, input int img_h);
        return $clog2(img_w * img_h + 1);
    endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers VSYNC/HSYNC and flags their edges; delay regs reset high
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic vsync,
    input  logic hsync,
    output logic hs_q,
    output logic vs_rise,
    output logic vs_fall,
    output logic hs_fall
);
    logic vs_q;
    // Resetting high hides a frame already running when reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b1;
            hs_q <= 1'b1;
        end else if (clear) begin
            vs_q <= 1'b1;
            hs_q <= 1'b1;
        end else begin
            vs_q <= vsync;
            hs_q <= hsync;
        end
    end
    assign vs_rise = vsync & ~vs_q;
    assign vs_fall = ~vsync & vs_q;
    assign hs_fall = ~hsync & hs_q;
endmodule

// File: rtl/frame_monitor.sv
// frame_monitor: per-frame pixel/line counts, geometry check and checksum of a VSYNC/HSYNC stream
module frame_monitor
    import pipe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CHANNELS = 1,
    parameter int IMG_W    = 768,
    parameter int IMG_H    = 512,
    parameter int CNT_W    = 20,
    parameter int CKSUM_W  = 32
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       VSYNC,
    input  logic                       HSYNC,
    input  logic [DATA_W*CHANNELS-1:0] data,
    input  logic                       clear,
    output logic                       busy,
    output logic                       frame_done,
    output logic [CNT_W-1:0]           pix_cnt,
    output logic [CNT_W-1:0]           line_cnt,
    output logic [CNT_W-1:0]           frame_cnt,
    output logic [CKSUM_W-1:0]         checksum,
    output logic                       err_size,
    output logic                       err_sync
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_W   = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] EXP_PIX = CNT_W'(IMG_W * IMG_H);

    if (CNT_W < min_cnt_w(IMG_W, IMG_H)) begin : g_cnt_w
        $error("frame_monitor: CNT_W too small for IMG_W*IMG_H");
    end

    state_t state, state_nx;
    logic hs_q, vs_rise, vs_fall, hs_fall;
    logic start, finish, count_en, line_end, act_first, size_viol, sync_viol;
    logic [CNT_W-1:0] pix_run, len_run, line_run;
    logic [CNT_W-1:0] pix_base, len_base, line_base, pix_nx, len_nx, line_nx;
    logic [CKSUM_W-1:0] sum_run, sum_base, sum_nx, pix_sum;

    sync_edge_det u_edge (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .clear   (clear),
        .vsync   (VSYNC),
        .hsync   (HSYNC),
        .hs_q    (hs_q),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall),
        .hs_fall (hs_fall)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = clear ? IDLE :
                   (state == IDLE && vs_rise) ? ACTIVE :
                   (state == ACTIVE && vs_fall) ? IDLE : state;
    end

    always_comb begin
        busy = state == ACTIVE;
    end

    always_comb begin
        pix_sum = '0;
        for (int i = 0; i < CHANNELS; i++)
            pix_sum = pix_sum + CKSUM_W'(data[i*DATA_W +: DATA_W]);
    end

    // Accumulators restart on the VSYNC rise, which may itself carry a pixel
    always_comb begin
        start     = state == IDLE && vs_rise;
        finish    = state == ACTIVE && vs_fall;
        count_en  = HSYNC && (start || state == ACTIVE);
        line_end  = state == ACTIVE && (hs_fall || (vs_fall && (HSYNC || hs_q)));
        pix_base  = start ? '0 : pix_run;
        len_base  = start ? '0 : len_run;
        line_base = start ? '0 : line_run;
        sum_base  = start ? '0 : sum_run;
        pix_nx    = pix_base + CNT_W'(count_en && pix_base != CNT_MAX);
        len_nx    = len_base + CNT_W'(count_en && len_base != CNT_MAX);
        line_nx   = line_base + CNT_W'(line_end);
        sum_nx    = sum_base + (count_en ? pix_sum : '0);
        size_viol = (count_en && (pix_nx == CNT_MAX || len_nx == CNT_MAX)) ||
                    (line_end && len_nx != EXP_W) ||
                    (finish && (line_nx != EXP_H || pix_nx != EXP_PIX));
        sync_viol = (state == IDLE && HSYNC && !vs_rise) ||
                    (state == ACTIVE && vs_rise) ||
                    (finish && act_first);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            act_first  <= 1'b0;
            pix_run    <= '0;
            len_run    <= '0;
            line_run   <= '0;
            sum_run    <= '0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_cnt  <= '0;
            checksum   <= '0;
            err_size   <= 1'b0;
            err_sync   <= 1'b0;
        end else if (clear) begin
            act_first  <= 1'b0;
            frame_done <= 1'b0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_cnt  <= '0;
            checksum   <= '0;
            err_size   <= 1'b0;
            err_sync   <= 1'b0;
        end else begin
            act_first  <= start;
            pix_run    <= pix_nx;
            len_run    <= line_end ? '0 : len_nx;
            line_run   <= line_nx;
            sum_run    <= sum_nx;
            frame_done <= finish;
            if (finish) begin
                pix_cnt   <= pix_nx;
                line_cnt  <= line_nx;
                checksum  <= sum_nx;
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            err_size <= err_size | size_viol;
            err_sync <= err_sync | sync_viol;
        end
    end
endmodule

// File: doc/frame_monitor.md
Name: frame_monitor

Overview:
Parametrised, synthesizable frame checker for the preprocessing pipeline's VSYNC/HSYNC/data pixel stream. It taps the stream at any stage (read, remover or write output) and does not modify it. Per frame it counts pixels and lines, checks frame geometry against the expected size, and accumulates a wrapping per-frame checksum. Benches use its results instead of dumping images, and they remain valid when channel count or image size changes.

Parameters:
DATA_W, 8, bits per channel
CHANNELS, 1, channels per pixel; data bus is DATA_W*CHANNELS, channel 0 in the LSBs
IMG_W, 768, expected pixels per line
IMG_H, 512, expected lines per frame
CNT_W, 20, width of pixel, line and frame counters
CKSUM_W, 32, checksum width

Ports:
HCLK  input  1  clock, rising edge
HRESETn  input  1  asynchronous active-low reset
VSYNC  input  1  high for the whole active frame
HSYNC  input  1  high on cycles carrying a valid pixel
data  input  DATA_W*CHANNELS  pixel, valid when HSYNC=1
clear  input  1  synchronous clear; same effect as reset
busy  output  1  high while a frame is in progress
frame_done  output  1  one-cycle pulse when a frame's results are latched
pix_cnt  output  CNT_W  pixel count of the last completed frame
line_cnt  output  CNT_W  line count of the last completed frame
frame_cnt  output  CNT_W  completed frames since reset or clear; wraps
checksum  output  CKSUM_W  sum of all channel values of the last frame, mod 2^CKSUM_W
err_size  output  1  sticky geometry error
err_sync  output  1  sticky protocol error

Behaviour:
- Reset or clear: all outputs 0.
  - Internal VSYNC delay register (vs_q) and HSYNC delay register (hs_q) reset to 1.
  - This ensures a frame already in progress at reset release is never counted.
  - clear has priority over every other event in its cycle.
- FSM with two states, IDLE and ACTIVE; busy=1 in ACTIVE.
- IDLE -> ACTIVE on the edge where VSYNC=1 and vs_q=0. Running pixel, line, length and sum accumulators start from 0.
  - A pixel with HSYNC=1 in that same cycle belongs to the new frame.
- ACTIVE, each edge with HSYNC=1:
  - The running pixel count and current line length each increment by 1.
  - Running sum adds all CHANNELS fields, each zero-extended, with wrap.
  - Pixel and length counters saturate at all-ones; reaching saturation sets err_size.
- Line end: detected on the edge where HSYNC=0 and hs_q=1, or where VSYNC falls while HSYNC or hs_q is still high.
  - Line counter increments by 1.
  - If line length != IMG_W, err_size is set. Line length then resets to 0.
- ACTIVE -> IDLE on the edge where VSYNC=0 and vs_q=1. On that edge:
  - pix_cnt, line_cnt and checksum latch the running values.
  - frame_cnt increments.
  - err_size is set if line count != IMG_H or pixel count != IMG_W*IMG_H.
  - frame_done is high for exactly the following cycle.
  - Latency from the VSYNC fall being sampled to frame_done: 1 cycle.
- err_sync is set by:
  - HSYNC=1 in IDLE; that pixel is not counted.
  - A VSYNC rising edge while already ACTIVE (impossible by edge detection; reserved).
  - A VSYNC high pulse shorter than 2 cycles.
- Sticky errors clear only on reset or clear.
- clear in ACTIVE aborts the frame: no frame_done, state IDLE. Monitoring restarts at the next VSYNC rise.
- Constraint: IMG_W*IMG_H must fit in CNT_W bits.
- Outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package, pipe_pkg: DATA_W default, state encoding (IDLE=0, ACTIVE=1), and a function computing the minimum CNT_W from IMG_W/IMG_H.
- One natural sub-module, sync_edge_det: registers VSYNC and HSYNC and produces rise/fall strobes with reset value 1. It is reused by later pipeline blocks.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3.
1. Clean frame, 3 lines of 4 pixels, data 1..12, one idle cycle between lines -> one frame_done pulse one cycle after VSYNC falls; pix_cnt=12, line_cnt=3, checksum=78, frame_cnt=1, no errors.
2. Line 2 carries only 3 pixels (data 1..11) -> err_size=1, pix_cnt=11, line_cnt=3, checksum=66; err_size stays 1 through a following clean frame and clears after a clear pulse.
3. HSYNC=1 for 2 cycles with VSYNC=0 -> err_sync=1; the next clean frame still reports pix_cnt=12.
4. HRESETn released mid-frame while VSYNC=1 -> no frame_done at that VSYNC fall; the next full frame gives frame_done with frame_cnt=1.
5. CHANNELS=3, every pixel {0x03,0x02,0x01}, 12 pixels -> checksum=72.
6. CKSUM_W=8, all data 0xFF -> checksum=0xF4 (3060 mod 256). Two back-to-back frames with VSYNC low for 1 cycle -> frame_cnt=2, and both frame_done pulses are present.
